// File: rtl/free_list_ckpt_pkg.sv
// Shared rename-stage constants and types for the physical-register free list.
package free_list_ckpt_pkg;
  localparam int PREG_WIDTH = 6;
  localparam int NUM_PREGS  = 64;
  localparam int NUM_AREGS  = 32;
  localparam int LANES      = 2;
  localparam int NUM_CKPT   = 4;
  localparam int DEPTH      = NUM_PREGS - NUM_AREGS;
  localparam int CKPT_W     = $clog2(NUM_CKPT);

  typedef logic [PREG_WIDTH-1:0] physicalIndexing;
  typedef logic [CKPT_W-1:0]     ckpt_id_t;
endpackage

// File: rtl/free_list_ckpt_lane_rank.sv
// Prefix rank of every set lane in a mask (set lanes strictly below it) plus total popcount.
module lane_rank
  import free_list_ckpt_pkg::*;
#(
  parameter int N_LANES = LANES,
  parameter int RW      = $clog2(N_LANES + 1)
) (
  input  logic [N_LANES-1:0]         i_mask,
  output logic [N_LANES-1:0][RW-1:0] o_rank,
  output logic [RW-1:0]              o_count
);

  logic [RW-1:0] w_acc;

  // Running count of set lanes, sampled before each lane is added.
  always_comb begin
    w_acc = {RW{1'b0}};
    for (int k = 0; k < N_LANES; k++) begin
      o_rank[k] = w_acc;
      w_acc     = w_acc + RW'(i_mask[k]);
    end
    o_count = w_acc;
  end

endmodule

// File: rtl/free_list_ckpt.sv
// Multi-lane physical-register free list with head-pointer checkpoints for one-cycle branch recovery.
module free_list_ckpt #(
  parameter int PREG_WIDTH = free_list_ckpt_pkg::PREG_WIDTH,
  parameter int NUM_PREGS  = free_list_ckpt_pkg::NUM_PREGS,
  parameter int NUM_AREGS  = free_list_ckpt_pkg::NUM_AREGS,
  parameter int LANES      = free_list_ckpt_pkg::LANES,
  parameter int NUM_CKPT   = free_list_ckpt_pkg::NUM_CKPT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [LANES-1:0]                     alloc_req,
  output logic                                 alloc_grant,
  output logic [LANES*PREG_WIDTH-1:0]          alloc_preg,
  input  logic [LANES-1:0]                     free_valid,
  input  logic [LANES*PREG_WIDTH-1:0]          free_preg,
  input  logic                                 ckpt_save,
  input  logic [$clog2(NUM_CKPT)-1:0]          ckpt_save_id,
  input  logic                                 restore,
  input  logic [$clog2(NUM_CKPT)-1:0]          restore_id,
  output logic [$clog2(NUM_PREGS-NUM_AREGS):0] free_count,
  output logic                                 empty,
  output logic                                 overflow_err
);

  localparam int DEP = NUM_PREGS - NUM_AREGS;
  localparam int AW  = $clog2(DEP);
  localparam int PW  = AW + 1;
  localparam int RW  = $clog2(LANES + 1);

  logic [PREG_WIDTH-1:0] r_mem  [DEP];
  logic [PW-1:0]         r_ckpt [NUM_CKPT];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic                  r_overflow;

  logic [LANES-1:0][RW-1:0] w_arank;
  logic [LANES-1:0][RW-1:0] w_frank;
  logic [RW-1:0]            w_n_req;
  logic [RW-1:0]            w_n_free;
  logic [PW-1:0]            w_count;
  logic [PW-1:0]            w_n_granted;
  logic [PW-1:0]            w_head_post;
  logic [PW:0]              w_occ_next;
  logic                     w_grant;
  logic                     w_drop;

  lane_rank #(.N_LANES(LANES), .RW(RW)) u_alloc_rank (
    .i_mask  (alloc_req),
    .o_rank  (w_arank),
    .o_count (w_n_req)
  );

  lane_rank #(.N_LANES(LANES), .RW(RW)) u_free_rank (
    .i_mask  (free_valid),
    .o_rank  (w_frank),
    .o_count (w_n_free)
  );

  // Grant decision, post-alloc head, overflow check and per-lane preg lookup.
  always_comb begin
    w_count     = r_tail - r_head;
    w_grant     = rst_n && !restore && (PW'(w_n_req) <= w_count);
    w_n_granted = w_grant ? PW'(w_n_req) : {PW{1'b0}};
    w_head_post = r_head + w_n_granted;
    // Extra bit so an over-full result cannot alias back into range.
    w_occ_next  = {1'b0, w_count} - {1'b0, w_n_granted} + (PW+1)'(w_n_free);
    w_drop      = (w_occ_next > (PW+1)'(DEP));
    for (int k = 0; k < LANES; k++) begin
      alloc_preg[k*PREG_WIDTH +: PREG_WIDTH] = r_mem[AW'(r_head + PW'(w_arank[k]))];
    end
  end

  // Head pointer and checkpoint slots; a restore overrides both allocation and save.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= {PW{1'b0}};
      for (int c = 0; c < NUM_CKPT; c++) begin
        r_ckpt[c] <= {PW{1'b0}};
      end
    end else begin
      if (restore) begin
        r_head <= r_ckpt[restore_id];
      end else begin
        r_head <= w_head_post;
        if (ckpt_save) begin
          r_ckpt[ckpt_save_id] <= w_head_post;
        end
      end
    end
  end

  // Tail pointer, entry storage and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail     <= PW'(DEP);
      r_overflow <= 1'b0;
      for (int i = 0; i < DEP; i++) begin
        r_mem[i] <= PREG_WIDTH'(NUM_AREGS + i);
      end
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else begin
        r_tail <= r_tail + PW'(w_n_free);
        for (int k = 0; k < LANES; k++) begin
          if (free_valid[k]) begin
            r_mem[AW'(r_tail + PW'(w_frank[k]))] <= free_preg[k*PREG_WIDTH +: PREG_WIDTH];
          end
        end
      end
    end
  end

  assign alloc_grant  = w_grant;
  assign free_count   = w_count;
  assign empty        = (w_count == {PW{1'b0}});
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_free_list_ckpt.sv
// Self-checking bench for free_list_ckpt: directed vector table, hand sequences, and random scoreboard.
module tb_free_list_ckpt;
  import free_list_ckpt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  alloc_req = 2'b00;
  logic        alloc_grant;
  logic [11:0] alloc_preg;
  logic [1:0]  free_valid = 2'b00;
  logic [11:0] free_preg = 12'd0;
  logic        ckpt_save = 1'b0;
  logic [1:0]  ckpt_save_id = 2'd0;
  logic        restore = 1'b0;
  logic [1:0]  restore_id = 2'd0;
  logic [5:0]  free_count;
  logic        empty;
  logic        overflow_err;

  int checks = 0;
  int failures = 0;

  free_list_ckpt dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_grant(alloc_grant),
    .alloc_preg(alloc_preg), .free_valid(free_valid), .free_preg(free_preg),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id), .restore(restore),
    .restore_id(restore_id), .free_count(free_count), .empty(empty),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    bit         rst;
    logic [1:0] req;
    logic [1:0] fv;
    logic [5:0] fp0;
    bit         eg;
    logic [1:0] pmask;
    logic [5:0] ep0;
    logic [5:0] ep1;
    int         ec;
    bit         eo;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string nm, bit rst, logic [1:0] req, logic [1:0] fv,
                              logic [5:0] fp0, bit eg, logic [1:0] pm,
                              logic [5:0] ep0, logic [5:0] ep1, int ec, bit eo);
    vec_t v;
    v.nm = nm; v.rst = rst; v.req = req; v.fv = fv; v.fp0 = fp0; v.eg = eg;
    v.pmask = pm; v.ep0 = ep0; v.ep1 = ep1; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    alloc_req = 2'b00; free_valid = 2'b00; free_preg = 12'd0;
    ckpt_save = 1'b0; restore = 1'b0; ckpt_save_id = 2'd0; restore_id = 2'd0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input logic [1:0] req, input logic [1:0] fv, input logic [5:0] fp0,
                     input bit sv, input logic [1:0] sid, input bit rs, input logic [1:0] rid);
    @(negedge clk);
    alloc_req = req; free_valid = fv; free_preg = {6'd0, fp0};
    ckpt_save = sv; ckpt_save_id = sid; restore = rs; restore_id = rid;
    #1;
  endtask

  task automatic chk_pair(input string nm, input int e0, input int e1);
    chk({nm, "_grant"}, int'(alloc_grant), 1);
    chk({nm, "_p0"}, int'(alloc_preg[5:0]), e0);
    chk({nm, "_p1"}, int'(alloc_preg[11:6]), e1);
  endtask

  physicalIndexing fq[$];
  physicalIndexing live[$];

  initial begin
    // Directed vectors; expected count/overflow are the values before this cycle's edge.
    vt.push_back(mk("a_first",     1'b1, 2'b11, 2'b00, 6'd0, 1'b1, 2'b11, 6'd32, 6'd33, 32, 1'b0));
    vt.push_back(mk("a_second",    1'b0, 2'b11, 2'b00, 6'd0, 1'b1, 2'b11, 6'd34, 6'd35, 30, 1'b0));
    vt.push_back(mk("a_idle",      1'b0, 2'b00, 2'b00, 6'd0, 1'b1, 2'b00, 6'd0,  6'd0,  28, 1'b0));
    vt.push_back(mk("b_lane1",     1'b1, 2'b10, 2'b00, 6'd0, 1'b1, 2'b10, 6'd0,  6'd32, 32, 1'b0));
    vt.push_back(mk("b_idle",      1'b0, 2'b00, 2'b00, 6'd0, 1'b1, 2'b00, 6'd0,  6'd0,  31, 1'b0));
    vt.push_back(mk("e_free_full", 1'b1, 2'b00, 2'b01, 6'd5, 1'b1, 2'b00, 6'd0,  6'd0,  32, 1'b0));
    vt.push_back(mk("e_sticky1",   1'b0, 2'b00, 2'b00, 6'd0, 1'b1, 2'b00, 6'd0,  6'd0,  32, 1'b1));
    vt.push_back(mk("e_sticky2",   1'b0, 2'b11, 2'b00, 6'd0, 1'b1, 2'b11, 6'd32, 6'd33, 32, 1'b1));
    vt.push_back(mk("e_after",     1'b0, 2'b00, 2'b00, 6'd0, 1'b1, 2'b00, 6'd0,  6'd0,  30, 1'b1));

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      cyc(vt[i].req, vt[i].fv, vt[i].fp0, 1'b0, 2'd0, 1'b0, 2'd0);
      chk({vt[i].nm, "_grant"}, int'(alloc_grant), int'(vt[i].eg));
      chk({vt[i].nm, "_count"}, int'(free_count), vt[i].ec);
      chk({vt[i].nm, "_empty"}, int'(empty), int'(vt[i].ec == 0));
      chk({vt[i].nm, "_ovf"}, int'(overflow_err), int'(vt[i].eo));
      if (vt[i].pmask[0]) chk({vt[i].nm, "_p0"}, int'(alloc_preg[5:0]), int'(vt[i].ep0));
      if (vt[i].pmask[1]) chk({vt[i].nm, "_p1"}, int'(alloc_preg[11:6]), int'(vt[i].ep1));
    end

    // Sticky flag cleared, full count and no grant while reset is asserted.
    @(negedge clk);
    alloc_req = 2'b11; free_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ovf", int'(overflow_err), 0);
    chk("rst_count", int'(free_count), 32);
    chk("rst_grant", int'(alloc_grant), 0);
    @(negedge clk);
    alloc_req = 2'b00;
    rst_n = 1'b1;

    // Drain to one entry, then a denied 2-lane alloc alongside a free.
    do_reset();
    for (int i = 0; i < 15; i++) cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(2'b01, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("c_grant_one", int'(alloc_grant), 1);
    chk("c_p_one", int'(alloc_preg[5:0]), 62);
    cyc(2'b11, 2'b01, 6'd5, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("c_count1", int'(free_count), 1);
    chk("c_deny", int'(alloc_grant), 0);
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("c_count2", int'(free_count), 2);
    chk_pair("c_after_free", 63, 5);
    cyc(2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("c_count0", int'(free_count), 0);
    chk("c_empty", int'(empty), 1);
    chk("c_ovf", int'(overflow_err), 0);

    // Checkpoint save in an alloc cycle, later restore, then save+restore on one slot.
    do_reset();
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk_pair("d_a0", 32, 33);
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk_pair("d_a1", 34, 35);
    cyc(2'b11, 2'b00, 6'd0, 1'b1, 2'd1, 1'b0, 2'd0);
    chk_pair("d_a2_save", 36, 37);
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk_pair("d_a3", 38, 39);
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk_pair("d_a5", 42, 43);
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b1, 2'd1);
    chk("d_restore_deny", int'(alloc_grant), 0);
    chk("d_restore_count", int'(free_count), 20);
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("d_restored_count", int'(free_count), 26);
    chk_pair("d_restored", 38, 39);
    cyc(2'b00, 2'b00, 6'd0, 1'b1, 2'd2, 1'b1, 2'd2);
    chk("d_sr_deny", int'(alloc_grant), 0);
    chk("d_sr_count", int'(free_count), 24);
    cyc(2'b11, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("d_sr_after", int'(free_count), 32);
    chk_pair("d_sr_alloc", 32, 33);
    cyc(2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 1'b1, 2'd2);
    chk("d_r2_before", int'(free_count), 30);
    cyc(2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("d_slot_kept", int'(free_count), 32);

    // Random alloc/free against a FIFO-of-free-pregs model.
    do_reset();
    fq.delete(); live.delete();
    for (int p = NUM_AREGS; p < NUM_PREGS; p++) fq.push_back(physicalIndexing'(p));
    for (int cy = 0; cy < 200; cy++) begin
      logic [1:0] req;
      logic [1:0] fv;
      logic [5:0] fp [2];
      int nreq;
      bit g;
      req = 2'($urandom_range(0, 3));
      fv = 2'b00;
      fp[0] = 6'd0; fp[1] = 6'd0;
      for (int k = 0; k < 2; k++) begin
        if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
          int idx;
          idx = $urandom_range(0, live.size() - 1);
          fp[k] = live[idx];
          live.delete(idx);
          fv[k] = 1'b1;
        end
      end
      cyc(req, fv, fp[0], 1'b0, 2'd0, 1'b0, 2'd0);
      free_preg = {fp[1], fp[0]};
      #1;
      nreq = int'(req[0]) + int'(req[1]);
      g = (nreq <= fq.size());
      chk("r_count", int'(free_count), fq.size());
      chk("r_grant", int'(alloc_grant), int'(g));
      if (g) begin
        int r;
        r = 0;
        for (int k = 0; k < 2; k++) begin
          if (req[k]) begin
            int got;
            bit dup;
            got = int'(alloc_preg[k*6 +: 6]);
            chk("r_preg", got, int'(fq[r]));
            dup = 1'b0;
            foreach (live[j]) if (int'(live[j]) == got) dup = 1'b1;
            chk("r_nodup", int'(dup), 0);
            r++;
          end
        end
        for (int k = 0; k < nreq; k++) live.push_back(fq.pop_front());
      end
      for (int k = 0; k < 2; k++) if (fv[k]) fq.push_back(fp[k]);
    end
    cyc(2'b00, 2'b00, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("r_final_count", int'(free_count), fq.size());
    chk("r_final_ovf", int'(overflow_err), 0);

    // Asynchronous reset mid-cycle with traffic applied.
    alloc_req = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", int'(free_count), 32);
    chk("mid_rst_grant", int'(alloc_grant), 0);
    @(negedge clk);
    alloc_req = 2'b00;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
